// File: rtl/row_scheduler_pkg.sv
// Shared constants and types for the SpMV row scheduler.
// Holds the datapath widths, the derived accumulator width, the
// per-channel FSM state encoding and a product sign-extension helper.
package row_scheduler_pkg;

  localparam int CHANNEL_NUM  = 4;
  localparam int VAL_BITS     = 16;
  localparam int ROW_LEN_SIZE = 8;
  localparam int ROW_ID_SIZE  = 16;

  localparam int PROD_BITS = 2 * VAL_BITS;
  // Wide enough that a row of up to 2^ROW_LEN_SIZE-1 products cannot overflow.
  localparam int ACC_BITS  = PROD_BITS + ROW_LEN_SIZE;
  localparam int CH_BITS   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_ACC  = 2'd1,
    CH_HOLD = 2'd2
  } ch_state_t;

  function automatic logic [ACC_BITS-1:0] sext_prod(input logic [PROD_BITS-1:0] p);
    return {{(ACC_BITS-PROD_BITS){p[PROD_BITS-1]}}, p};
  endfunction

endpackage

// File: rtl/row_channel_ctrl.sv
// One channel of the row scheduler: pops a row length, accumulates that
// many signed products into a row sum, then holds the sum until the
// arbiter grants it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_len/i_len_empty   FWFT head of the length FIFO; o_len_read pops it
//   i_mult/i_mult_empty FWFT head of the product FIFO; o_mult_read pops it
//   i_grant             arbiter grant (only asserted while o_hold=1)
//   o_hold              channel has a finished sum waiting
//   o_sum, o_row_id     finished sum and its row index
//   o_state             FSM state for observation
module row_channel_ctrl
  import row_scheduler_pkg::*;
#(
  parameter int CH_IDX = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ROW_LEN_SIZE-1:0] i_len,
  input  logic                    i_len_empty,
  output logic                    o_len_read,
  input  logic [PROD_BITS-1:0]    i_mult,
  input  logic                    i_mult_empty,
  output logic                    o_mult_read,
  input  logic                    i_grant,
  output logic                    o_hold,
  output logic [ACC_BITS-1:0]     o_sum,
  output logic [ROW_ID_SIZE-1:0]  o_row_id,
  output ch_state_t               o_state
);

  ch_state_t               r_state;
  logic [ACC_BITS-1:0]     r_acc;
  logic [ROW_LEN_SIZE-1:0] r_remaining;
  logic [ROW_ID_SIZE-1:0]  r_row_id;

  // Pops are combinational from the registered state so a FWFT head is
  // consumed in the same cycle it is seen; rst forces them low.
  assign o_len_read  = !rst && (r_state == CH_IDLE) && !i_len_empty;
  assign o_mult_read = !rst && (r_state == CH_ACC)  && !i_mult_empty;

  assign o_hold   = (r_state == CH_HOLD);
  assign o_sum    = r_acc;
  assign o_row_id = r_row_id;
  assign o_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CH_IDLE;
      r_acc       <= '0;
      r_remaining <= '0;
      r_row_id    <= ROW_ID_SIZE'(CH_IDX);
    end else begin
      case (r_state)
        CH_IDLE: begin
          if (!i_len_empty) begin
            r_remaining <= i_len;
            r_acc       <= '0;
            r_state     <= (i_len == '0) ? CH_HOLD : CH_ACC;
          end
        end
        CH_ACC: begin
          // An empty product FIFO simply stalls here.
          if (!i_mult_empty) begin
            r_acc       <= r_acc + sext_prod(i_mult);
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == ROW_LEN_SIZE'(1)) r_state <= CH_HOLD;
          end
        end
        CH_HOLD: begin
          if (i_grant) begin
            r_state  <= CH_IDLE;
            r_row_id <= r_row_id + ROW_ID_SIZE'(CHANNEL_NUM);
          end
        end
        default: r_state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/row_scheduler.sv
// SpMV row scheduler top: one row_channel_ctrl per channel, a round-robin
// arbiter over channels holding finished sums, a single result output
// register and an accepted-result counter.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   len, len_fifo_empty, len_fifo_read    per-channel row-length FIFOs
//   mult, mult_fifo_empty, mult_fifo_read per-channel product FIFOs
//   res_valid/res_ready              result handshake
//   res_sum, res_row, res_channel    result payload
//   rows_done                        count of accepted results (wraps)
//   dbg_ch_state                     2-bit FSM state per channel
//
// Result handshake: a result transfers on every clock edge where
// res_valid && res_ready. While res_valid && !res_ready the payload is
// frozen. A new result may be loaded in the same cycle the current one
// transfers, so res_valid stays high across back-to-back results.
module row_scheduler
  import row_scheduler_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ROW_LEN_SIZE*CHANNEL_NUM-1:0] len,
  input  logic [CHANNEL_NUM-1:0]            len_fifo_empty,
  output logic [CHANNEL_NUM-1:0]            len_fifo_read,
  input  logic [PROD_BITS*CHANNEL_NUM-1:0]  mult,
  input  logic [CHANNEL_NUM-1:0]            mult_fifo_empty,
  output logic [CHANNEL_NUM-1:0]            mult_fifo_read,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ACC_BITS-1:0]               res_sum,
  output logic [ROW_ID_SIZE-1:0]            res_row,
  output logic [CH_BITS-1:0]                res_channel,
  output logic [ROW_ID_SIZE-1:0]            rows_done,
  output logic [2*CHANNEL_NUM-1:0]          dbg_ch_state
);

  logic [CHANNEL_NUM-1:0] w_hold;
  logic [CHANNEL_NUM-1:0] w_grant;
  logic [ACC_BITS-1:0]    w_sum   [CHANNEL_NUM];
  logic [ROW_ID_SIZE-1:0] w_row   [CHANNEL_NUM];
  ch_state_t              w_state [CHANNEL_NUM];

  logic                   w_out_free;
  logic                   w_grant_valid;
  logic [CH_BITS-1:0]     w_grant_idx;
  logic [CH_BITS-1:0]     w_ptr_next;

  logic [CH_BITS-1:0]     r_ptr;
  logic                   r_res_valid;
  logic [ACC_BITS-1:0]    r_res_sum;
  logic [ROW_ID_SIZE-1:0] r_res_row;
  logic [CH_BITS-1:0]     r_res_channel;
  logic [ROW_ID_SIZE-1:0] r_rows_done;

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
    row_channel_ctrl #(
      .CH_IDX(g)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_len        (len[g*ROW_LEN_SIZE +: ROW_LEN_SIZE]),
      .i_len_empty  (len_fifo_empty[g]),
      .o_len_read   (len_fifo_read[g]),
      .i_mult       (mult[g*PROD_BITS +: PROD_BITS]),
      .i_mult_empty (mult_fifo_empty[g]),
      .o_mult_read  (mult_fifo_read[g]),
      .i_grant      (w_grant[g]),
      .o_hold       (w_hold[g]),
      .o_sum        (w_sum[g]),
      .o_row_id     (w_row[g]),
      .o_state      (w_state[g])
    );
    assign dbg_ch_state[2*g +: 2] = w_state[g];
  end

  // Round-robin: scan from r_ptr upward (wrapping) and take the first
  // channel in HOLD, but only when the output register can accept.
  always_comb begin
    logic [CH_BITS-1:0] v_idx;
    v_idx         = '0;
    w_grant       = '0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_out_free    = !r_res_valid || res_ready;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      v_idx = CH_BITS'((int'(r_ptr) + k) % CHANNEL_NUM);
      if (w_out_free && !w_grant_valid && w_hold[v_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = v_idx;
      end
    end
    if (w_grant_valid) w_grant[w_grant_idx] = 1'b1;
    w_ptr_next = CH_BITS'((int'(w_grant_idx) + 1) % CHANNEL_NUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= '0;
      r_res_valid   <= 1'b0;
      r_res_sum     <= '0;
      r_res_row     <= '0;
      r_res_channel <= '0;
      r_rows_done   <= '0;
    end else begin
      if (w_grant_valid) begin
        r_res_valid   <= 1'b1;
        r_res_sum     <= w_sum[w_grant_idx];
        r_res_row     <= w_row[w_grant_idx];
        r_res_channel <= w_grant_idx;
        r_ptr         <= w_ptr_next;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (r_res_valid && res_ready) r_rows_done <= r_rows_done + 1'b1;
    end
  end

  assign res_valid   = r_res_valid;
  assign res_sum     = r_res_sum;
  assign res_row     = r_res_row;
  assign res_channel = r_res_channel;
  assign rows_done   = r_rows_done;

endmodule

// File: tb/tb_row_scheduler.sv
// Bench for row_scheduler: FWFT FIFO models per channel, a result
// scoreboard fed when rows are pushed, and directed scenarios.
module tb_row_scheduler;
  import row_scheduler_pkg::*;

  localparam int NCH   = CHANNEL_NUM;
  localparam int EXP_W = ACC_BITS + ROW_ID_SIZE + CH_BITS;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ROW_LEN_SIZE*NCH-1:0] len;
  logic [NCH-1:0]              len_fifo_empty;
  logic [NCH-1:0]              len_fifo_read;
  logic [PROD_BITS*NCH-1:0]    mult;
  logic [NCH-1:0]              mult_fifo_empty;
  logic [NCH-1:0]              mult_fifo_read;
  logic                        res_valid;
  logic                        res_ready;
  logic [ACC_BITS-1:0]         res_sum;
  logic [ROW_ID_SIZE-1:0]      res_row;
  logic [CH_BITS-1:0]          res_channel;
  logic [ROW_ID_SIZE-1:0]      rows_done;
  logic [2*NCH-1:0]            dbg_ch_state;

  row_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .len             (len),
    .len_fifo_empty  (len_fifo_empty),
    .len_fifo_read   (len_fifo_read),
    .mult            (mult),
    .mult_fifo_empty (mult_fifo_empty),
    .mult_fifo_read  (mult_fifo_read),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_sum         (res_sum),
    .res_row         (res_row),
    .res_channel     (res_channel),
    .rows_done       (rows_done),
    .dbg_ch_state    (dbg_ch_state)
  );

  // ---------------- FIFO models / scoreboard state ----------------
  logic [ROW_LEN_SIZE-1:0] len_mem  [NCH][DEPTH];
  logic [PROD_BITS-1:0]    mult_mem [NCH][DEPTH];
  int len_wr [NCH];
  int len_rd [NCH];
  int mult_wr[NCH];
  int mult_rd[NCH];
  int len_pops [NCH];
  int mult_pops[NCH];
  int len_last_cyc [NCH];
  int mult_last_cyc[NCH];
  logic [NCH-1:0] pend_len  = '0;
  logic [NCH-1:0] pend_mult = '0;

  int   cyc = 0;
  int   valid_rise_cyc = 0;
  int   hs_cnt = 0;
  logic prev_valid = 1'b0;
  int   hs_cyc[$];

  logic [EXP_W-1:0]       exp_q[$];
  logic [ROW_ID_SIZE-1:0] exp_row[NCH];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ACC_BITS-1:0] tb_sext(input logic [PROD_BITS-1:0] p);
    return ACC_BITS'($signed(p));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int c = 0; c < NCH; c++) begin
      len_fifo_empty[c]  = (len_rd[c] == len_wr[c]);
      mult_fifo_empty[c] = (mult_rd[c] == mult_wr[c]);
      len[c*ROW_LEN_SIZE +: ROW_LEN_SIZE] = len_fifo_empty[c] ?
        ROW_LEN_SIZE'($urandom) : len_mem[c][len_rd[c]];
      mult[c*PROD_BITS +: PROD_BITS] = mult_fifo_empty[c] ?
        PROD_BITS'($urandom) : mult_mem[c][mult_rd[c]];
    end
  endtask

  task automatic push_len(input int c, input logic [ROW_LEN_SIZE-1:0] l);
    len_mem[c][len_wr[c]] = l;
    len_wr[c]++;
    drive_inputs();
  endtask

  task automatic push_mult(input int c, input logic [PROD_BITS-1:0] p);
    mult_mem[c][mult_wr[c]] = p;
    mult_wr[c]++;
    drive_inputs();
  endtask

  task automatic expect_row(input int c, input logic [ACC_BITS-1:0] sum);
    exp_q.push_back({sum, exp_row[c], CH_BITS'(c)});
    exp_row[c] = exp_row[c] + ROW_ID_SIZE'(NCH);
  endtask

  task automatic clear_fifos();
    for (int c = 0; c < NCH; c++) begin
      len_wr[c] = 0; len_rd[c] = 0; mult_wr[c] = 0; mult_rd[c] = 0;
      exp_row[c] = ROW_ID_SIZE'(c);
    end
    exp_q.delete();
    drive_inputs();
  endtask

  task automatic to_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic to_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut(input int ncyc);
    rst = 1'b1;
    clear_fifos();
    repeat (ncyc) to_drive();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      to_sample();
      if (exp_q.size() == 0) break;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    to_drive();
  endtask

  // FIFO pops decided at the negedge are applied just after the edge.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (pend_len[c])  len_rd[c]++;
      if (pend_mult[c]) mult_rd[c]++;
    end
    pend_len  = '0;
    pend_mult = '0;
    drive_inputs();
  end

  // Monitor: records pops, checks protocol, pops the scoreboard.
  always @(negedge clk) begin
    cyc++;
    pend_len  = len_fifo_read;
    pend_mult = mult_fifo_read;
    check("rd_while_empty",
          64'({len_fifo_read & len_fifo_empty, mult_fifo_read & mult_fifo_empty}), 64'd0);
    for (int c = 0; c < NCH; c++) begin
      if (pend_len[c])  begin len_pops[c]++;  len_last_cyc[c]  = cyc; end
      if (pend_mult[c]) begin mult_pops[c]++; mult_last_cyc[c] = cyc; end
    end
    if (rst) begin
      check("rd_in_rst", 64'({len_fifo_read, mult_fifo_read}), 64'd0);
      hs_cnt     = 0;
      prev_valid = 1'b0;
    end else begin
      check("rows_done", 64'(rows_done), 64'(hs_cnt[ROW_ID_SIZE-1:0]));
      if (res_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = res_valid;
      if (res_valid && res_ready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(res_valid && res_ready), 64'(exp_q.size() != 0));
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          check("result", 64'({res_sum, res_row, res_channel}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int l0, m0, m1, m2, tot;
    logic [PROD_BITS-1:0] a, b;
    logic [ACC_BITS-1:0]  s;

    res_ready = 1'b1;
    rst = 1'b1;
    clear_fifos();

    // Reset with all FIFOs non-empty: nothing may be consumed.
    for (int c = 0; c < NCH; c++) begin
      push_len(c, 8'd1);
      push_mult(c, PROD_BITS'(c + 1));
    end
    repeat (3) to_drive();
    to_sample();
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_rows_done", 64'(rows_done), 64'd0);
    check("rst_sum", 64'(res_sum), 64'd0);
    check("rst_row", 64'(res_row), 64'd0);
    check("rst_channel", 64'(res_channel), 64'd0);
    check("rst_state", 64'(dbg_ch_state), 64'd0);
    tot = 0;
    for (int c = 0; c < NCH; c++) tot += len_rd[c] + mult_rd[c];
    check("rst_consumed", 64'(tot), 64'd0);
    to_drive();
    clear_fifos();
    rst = 1'b0;

    // Single row on ch0: 5 - 2 + 10 = 13.
    l0 = len_pops[0];
    m0 = mult_pops[0];
    push_len(0, 8'd3);
    push_mult(0, 32'd5);
    push_mult(0, 32'hFFFF_FFFE);
    push_mult(0, 32'd10);
    expect_row(0, 40'd13);
    wait_drain("single_drain", 40);
    check("single_len_pops", 64'(len_pops[0] - l0), 64'd1);
    check("single_mult_pops", 64'(mult_pops[0] - m0), 64'd3);
    check("single_pop_span", 64'(mult_last_cyc[0] - len_last_cyc[0]), 64'd3);
    check("single_latency", 64'(valid_rise_cyc - mult_last_cyc[0]), 64'd2);

    // Zero-length row on ch1.
    m1 = mult_pops[1];
    push_len(1, 8'd0);
    expect_row(1, 40'd0);
    wait_drain("zero_drain", 40);
    repeat (3) to_drive();
    check("zero_no_mult", 64'(mult_pops[1] - m1), 64'd0);

    // Contention: all channels finish together, two rounds.
    reset_dut(2);
    for (int round = 0; round < 2; round++) begin
      hs_cyc.delete();
      for (int c = 0; c < NCH; c++) begin
        a = PROD_BITS'($urandom);
        b = PROD_BITS'($urandom);
        push_len(c, 8'd2);
        push_mult(c, a);
        push_mult(c, b);
        s = tb_sext(a) + tb_sext(b);
        expect_row(c, s);
      end
      wait_drain("contend_drain", 60);
      for (int i = 1; i < NCH; i++)
        check("contend_back_to_back", 64'(hs_cyc[i] - hs_cyc[0]), 64'(i));
      to_sample();
      check("contend_rows_done", 64'(rows_done), 64'(4 * (round + 1)));
      to_drive();
    end

    // Backpressure: output held, channel in HOLD issues no len pops.
    res_ready = 1'b0;
    l0 = len_pops[0];
    for (int r = 0; r < 3; r++) begin
      push_len(0, 8'd1);
      push_mult(0, PROD_BITS'(3 + r));
      expect_row(0, ACC_BITS'(3 + r));
    end
    for (int i = 0; i < 20; i++) begin
      to_sample();
      if (res_valid) break;
    end
    check("bp_valid_seen", 64'(res_valid), 64'd1);
    repeat (5) to_sample();
    for (int i = 0; i < 10; i++) begin
      to_sample();
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_payload", 64'({res_sum, res_row, res_channel}), 64'(exp_q[0]));
      check("bp_len_pops", 64'(len_pops[0] - l0), 64'd2);
      check("bp_ch0_hold", 64'(dbg_ch_state[1:0]), 64'(CH_HOLD));
    end
    to_drive();
    res_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // Bubble on ch2 mid-row while ch3 completes independently.
    m2 = mult_pops[2];
    push_len(2, 8'd4);
    push_mult(2, 32'd1000);
    push_mult(2, 32'hFFFF_FFFD);
    push_len(3, 8'd1);
    push_mult(3, 32'd42);
    expect_row(3, 40'd42);
    s = tb_sext(32'd1000) + tb_sext(32'hFFFF_FFFD) + tb_sext(32'd77) + tb_sext(32'h7FFF_FFFF);
    expect_row(2, s);
    repeat (8) to_drive();
    check("stall_pops", 64'(mult_pops[2] - m2), 64'd2);
    check("stall_ch2_acc", 64'(dbg_ch_state[5:4]), 64'(CH_ACC));
    check("stall_other_done", 64'(exp_q.size()), 64'd1);
    push_mult(2, 32'd77);
    push_mult(2, 32'h7FFF_FFFF);
    wait_drain("stall_drain", 40);

    // Extremes; pointer now sits at ch3 so ch3 is served before ch0.
    push_len(3, 8'd2);
    push_mult(3, 32'h4000_0000);
    push_mult(3, 32'h4000_0000);
    push_len(0, 8'd2);
    push_mult(0, 32'h8000_0000);
    push_mult(0, 32'h8000_0000);
    expect_row(3, 40'h00_8000_0000);
    expect_row(0, 40'hFF_0000_0000);
    wait_drain("extreme_drain", 40);

    // Reset in the middle of a ch3 row: no result, row id restarts at 3.
    push_len(3, 8'd3);
    push_mult(3, 32'd7);
    repeat (4) to_drive();
    check("midrst_ch3_acc", 64'(dbg_ch_state[7:6]), 64'(CH_ACC));
    reset_dut(2);
    repeat (4) to_drive();
    check("midrst_state", 64'(dbg_ch_state), 64'd0);
    check("midrst_no_valid", 64'(res_valid), 64'd0);
    push_len(3, 8'd1);
    push_mult(3, 32'd9);
    expect_row(3, 40'd9);
    wait_drain("midrst_drain", 40);

    to_sample();
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
